pipe_hazard_scoreboard: RTL and testbench
=========================================

PIPE_HAZARD_SCOREBOARD -- requirements
Module: pipe_hazard_scoreboard

Interface
REQ-001 Parameter NSTAGE, default 3, meaning: number of post-decode pipeline entries tracked; entry 0 youngest, entry NSTAGE-1 writeback; legal range 2..8.
REQ-002 Parameter NSRC, default 2, meaning: source operands per instruction.
REQ-003 Parameter REGW, default 5, meaning: register-number width.
REQ-004 Parameter FWD_EN, default 1, meaning: 1 = forward where possible, 0 = stall-only mode.
REQ-005 Parameter LOAD_STAGE, default 1, meaning: lowest entry index from which a load result is forwardable.
REQ-006 Parameter FLUSH_N, default 2, meaning: number of youngest entries cleared by a flush; range 1..NSTAGE.
REQ-007 Derived SELW = clog2(NSTAGE+1).
REQ-008 CLK  in  1  clock; all state updates on its rising edge.
REQ-009 nRST  in  1  reset; synchronous, active-low.
REQ-010 id_valid  in  1  decode stage holds a valid instruction.
REQ-011 id_src  in  NSRC*REGW  source register numbers, source s at bits [s*REGW +: REGW].
REQ-012 id_src_used  in  NSRC  per-source read flag.
REQ-013 id_dst  in  REGW  destination register.
REQ-014 id_wr  in  1  instruction writes id_dst.
REQ-015 id_load  in  1  result comes from data memory.
REQ-016 advance  in  1  pipeline moves this cycle; 0 freezes all entries.
REQ-017 flush  in  1  branch/jump squash; sampled only when advance=1.
REQ-018 stall_out  out  1  decode instruction must hold; a bubble issues instead.
REQ-019 fwd_sel  out  NSRC*SELW  per source: 0 = register file, k = result of entry k-1.
REQ-020 occ  out  NSTAGE  valid bit of each entry.
REQ-021 stall_cnt  out  32  count of stall cycles.

Function
REQ-022 Each entry SHALL hold {valid, wr, load, dst}.
REQ-023 On advance=1, flush=0: entry 0 SHALL load the decode instruction if id_valid=1 and stall_out=0, else a bubble (valid=0); entry k SHALL load entry k-1; entry NSTAGE-1 contents retire.
REQ-024 On advance=1, flush=1: the decode instruction SHALL NOT issue; entries 0..FLUSH_N-1 SHALL load bubbles; entries FLUSH_N..NSTAGE-1 shift normally.
REQ-025 On advance=0 all entries and stall_cnt SHALL hold, regardless of flush.
REQ-026 Source s matches entry k when id_src_used[s]=1, source != 0, entry valid=1, wr=1, dst equals source; register 0 SHALL never match.
REQ-027 Multiple matches SHALL resolve to the youngest (lowest k).
REQ-028 FWD_EN=1: matched load entry with k < LOAD_STAGE SHALL assert stall_out; otherwise fwd_sel[s] = k+1.
REQ-029 FWD_EN=0: match with k < NSTAGE-1 SHALL assert stall_out; match only in entry NSTAGE-1 gives fwd_sel[s]=0, no stall (register file delivers same-cycle write data).
REQ-030 stall_out SHALL be 0 when id_valid=0; stall_out is the OR over all sources.
REQ-031 fwd_sel[s] SHALL be 0 when no match or when stall_out=1.
REQ-032 stall_out, fwd_sel SHALL be combinational from current entries and id inputs (zero latency); occ SHALL reflect registered valid bits.
REQ-033 stall_cnt SHALL increment when stall_out=1 and advance=1, saturating at 0xFFFFFFFF.

Reset
REQ-034 nRST=0 at a rising edge SHALL clear all entries to invalid and stall_cnt to 0, with priority over advance and flush.
REQ-035 After reset: occ=0, stall_out=0, fwd_sel=0, stall_cnt=0.

Verification (defaults unless stated)
REQ-036 nRST=0 two cycles with id_valid=1, advance=1, id_wr=1 -> occ=000, stall_cnt=0, stall_out=0, fwd_sel=0.
REQ-037 Issue ALU wr dst=3; next decode src0=3 -> fwd_sel[0]=1, stall_out=0; with one bubble between -> fwd_sel[0]=2; producers of r4 in entries 0 and 1 -> fwd_sel=1.
REQ-038 Issue load dst=5; next decode src1=5 -> stall_out=1 one cycle, stall_cnt=1, then fwd_sel[1]=2, stall_out=0; same with advance=0 for 3 cycles -> occ, stall_cnt unchanged.
REQ-039 Producer wr dst=0, consumer src0=0 -> fwd_sel[0]=0, stall_out=0.
REQ-040 Producer dst=7 in entry 1, flush with advance=1 (FLUSH_N=2) -> occ=000 except entry 2 shifted from entry 1 (occ=100); consumer src=7 -> fwd_sel=3, no stall.
REQ-041 FWD_EN=0, producer dst=2 issued, consumer src0=2 -> stall_out=1 for 2 cycles, then fwd_sel=0, stall_out=0, stall_cnt=2.

Source files
------------

// File: rtl/pipe_hazard_scoreboard.sv
// Register-dependency scoreboard for an in-order pipeline: tracks in-flight
// writers, decides stall vs. forward for each decode source operand.

module pipe_hazard_src #(
    parameter int NSTAGE     = 3,
    parameter int REGW       = 5,
    parameter int FWD_EN     = 1,
    parameter int LOAD_STAGE = 1,
    parameter int SELW       = 2
) (
    input  logic                         used,
    input  logic [REGW-1:0]              src,
    input  logic [NSTAGE-1:0]            ent_v,
    input  logic [NSTAGE-1:0]            ent_wr,
    input  logic [NSTAGE-1:0]            ent_ld,
    input  logic [NSTAGE-1:0][REGW-1:0]  ent_dst,
    output logic                         need_stall,
    output logic [SELW-1:0]              sel
);
    logic hit;
    int   hk;

    always_comb begin
        hit        = 1'b0;
        hk         = 0;
        need_stall = 1'b0;
        sel        = '0;
        // Scan oldest to youngest so the youngest producer wins.
        for (int k = NSTAGE-1; k >= 0; k--) begin
            if (used && src != '0 && ent_v[k] && ent_wr[k] && ent_dst[k] == src) begin
                hit = 1'b1;
                hk  = k;
            end
        end
        if (hit) begin
            if (FWD_EN != 0) begin
                if (ent_ld[hk] && hk < LOAD_STAGE) need_stall = 1'b1;
                else                               sel = SELW'(hk + 1);
            end else if (hk < NSTAGE-1) begin
                need_stall = 1'b1;
            end
        end
    end
endmodule

module pipe_hazard_scoreboard #(
    parameter int NSTAGE     = 3,
    parameter int NSRC       = 2,
    parameter int REGW       = 5,
    parameter int FWD_EN     = 1,
    parameter int LOAD_STAGE = 1,
    parameter int FLUSH_N    = 2,
    localparam int SELW      = $clog2(NSTAGE+1)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   id_valid,
    input  logic [NSRC*REGW-1:0]   id_src,
    input  logic [NSRC-1:0]        id_src_used,
    input  logic [REGW-1:0]        id_dst,
    input  logic                   id_wr,
    input  logic                   id_load,
    input  logic                   advance,
    input  logic                   flush,
    output logic                   stall_out,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic [NSTAGE-1:0]      occ,
    output logic [31:0]            stall_cnt
);
    localparam logic [NSTAGE-1:0] FLUSH_MASK = NSTAGE'((1 << FLUSH_N) - 1);

    logic [NSTAGE-1:0]           ent_v, ent_wr, ent_ld;
    logic [NSTAGE-1:0][REGW-1:0] ent_dst;
    logic [NSRC-1:0]             src_stall;
    logic [NSRC-1:0][SELW-1:0]   src_sel;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        pipe_hazard_src #(
            .NSTAGE(NSTAGE), .REGW(REGW), .FWD_EN(FWD_EN),
            .LOAD_STAGE(LOAD_STAGE), .SELW(SELW)
        ) u_src (
            .used       (id_src_used[s]),
            .src        (id_src[s*REGW +: REGW]),
            .ent_v      (ent_v),
            .ent_wr     (ent_wr),
            .ent_ld     (ent_ld),
            .ent_dst    (ent_dst),
            .need_stall (src_stall[s]),
            .sel        (src_sel[s])
        );
        assign fwd_sel[s*SELW +: SELW] = stall_out ? '0 : src_sel[s];
    end

    assign stall_out = id_valid & (|src_stall);
    assign occ       = ent_v;

    // A stalled or flushed decode slot enters the pipe as a bubble.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ent_v     <= '0;
            stall_cnt <= '0;
        end else if (advance) begin
            if (stall_out && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            ent_v <= {ent_v[NSTAGE-2:0], id_valid & ~stall_out & ~flush}
                     & ~(flush ? FLUSH_MASK : '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (advance) begin
            ent_wr  <= {ent_wr[NSTAGE-2:0], id_wr};
            ent_ld  <= {ent_ld[NSTAGE-2:0], id_load};
            ent_dst <= {ent_dst[NSTAGE-2:0], id_dst};
        end
    end
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench: forwarding and stall-only scoreboards driven by one stimulus stream,
// each checked against an array-based model every cycle plus directed literals.

module tb_pipe_hazard_scoreboard;
    localparam int NS = 3, NSRC = 2, REGW = 5, SELW = 2, LOAD_STAGE = 1, FLUSH_N = 2;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                 nRST, id_valid, id_wr, id_load, advance, flush;
    logic [NSRC*REGW-1:0] id_src;
    logic [NSRC-1:0]      id_src_used;
    logic [REGW-1:0]      id_dst;

    logic                 stall_a, stall_b;
    logic [NSRC*SELW-1:0] fwd_a, fwd_b;
    logic [NS-1:0]        occ_a, occ_b;
    logic [31:0]          cnt_a, cnt_b;

    pipe_hazard_scoreboard #(.FWD_EN(1)) dut_a (
        .CLK(CLK), .nRST(nRST), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_dst(id_dst), .id_wr(id_wr), .id_load(id_load),
        .advance(advance), .flush(flush), .stall_out(stall_a), .fwd_sel(fwd_a),
        .occ(occ_a), .stall_cnt(cnt_a));

    pipe_hazard_scoreboard #(.FWD_EN(0)) dut_b (
        .CLK(CLK), .nRST(nRST), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_dst(id_dst), .id_wr(id_wr), .id_load(id_load),
        .advance(advance), .flush(flush), .stall_out(stall_b), .fwd_sel(fwd_b),
        .occ(occ_b), .stall_cnt(cnt_b));

    int n_cmp = 0, n_bad = 0;
    bit started = 0;

    // Model: index 0 = forwarding instance, 1 = stall-only instance.
    bit              mv[2][NS], mw[2][NS], ml[2][NS];
    int              md[2][NS];
    longint unsigned mcnt[2];
    bit              estall[2];
    int              esel[2][NSRC];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_eval();
        for (int i = 0; i < 2; i++) begin
            estall[i] = 0;
            for (int s = 0; s < NSRC; s++) begin
                int src = int'(id_src[s*REGW +: REGW]);
                int hit = -1;
                esel[i][s] = 0;
                if (id_src_used[s] && src != 0)
                    for (int k = NS-1; k >= 0; k--)
                        if (mv[i][k] && mw[i][k] && md[i][k] == src) hit = k;
                if (hit >= 0) begin
                    if (i == 0) begin
                        if (ml[i][hit] && hit < LOAD_STAGE) estall[i] = 1;
                        else esel[i][s] = hit + 1;
                    end else if (hit < NS-1) estall[i] = 1;
                end
            end
            if (!id_valid) estall[i] = 0;
            if (estall[i]) for (int s = 0; s < NSRC; s++) esel[i][s] = 0;
        end
    endfunction

    function automatic void model_clk();
        for (int i = 0; i < 2; i++) begin
            if (!nRST) begin
                for (int k = 0; k < NS; k++) mv[i][k] = 0;
                mcnt[i] = 0;
            end else if (advance) begin
                if (estall[i] && mcnt[i] != 64'hFFFF_FFFF) mcnt[i]++;
                for (int k = NS-1; k > 0; k--) begin
                    mv[i][k] = mv[i][k-1]; mw[i][k] = mw[i][k-1];
                    ml[i][k] = ml[i][k-1]; md[i][k] = md[i][k-1];
                end
                mv[i][0] = id_valid && !estall[i] && !flush;
                mw[i][0] = id_wr; ml[i][0] = id_load; md[i][0] = int'(id_dst);
                if (flush) for (int k = 0; k < FLUSH_N; k++) mv[i][k] = 0;
            end
        end
    endfunction

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            logic [NS-1:0]        eo;
            logic [NSRC*SELW-1:0] ef;
            for (int k = 0; k < NS; k++) eo[k] = mv[i][k];
            for (int s = 0; s < NSRC; s++) ef[s*SELW +: SELW] = SELW'(esel[i][s]);
            chk(i == 0 ? "occ_a"   : "occ_b",   i == 0 ? occ_a   : occ_b,   eo);
            chk(i == 0 ? "stall_a" : "stall_b", i == 0 ? stall_a : stall_b, estall[i]);
            chk(i == 0 ? "fwd_a"   : "fwd_b",   i == 0 ? fwd_a   : fwd_b,   ef);
            chk(i == 0 ? "cnt_a"   : "cnt_b",   i == 0 ? cnt_a   : cnt_b,   mcnt[i]);
        end
    endtask

    task automatic settle();
        @(negedge CLK);
        model_eval();
        if (started) compare();
    endtask

    task automatic clk();
        @(posedge CLK);
        model_clk();
        started = 1;
        #1;
    endtask

    task automatic drive(input bit v, input int s0, input int s1, input bit [1:0] used,
                         input int dst, input bit wr, input bit ld, input bit adv, input bit fl);
        id_valid = v; id_src = {REGW'(s1), REGW'(s0)}; id_src_used = used;
        id_dst = REGW'(dst); id_wr = wr; id_load = ld; advance = adv; flush = fl;
    endtask

    task automatic do_reset();
        nRST = 0;
        drive(1, 3, 3, 2'b11, 3, 1, 0, 1, 0);
        repeat (2) begin settle(); clk(); end
        nRST = 1;
    endtask

    task automatic issue(input int dst, input bit ld);
        drive(1, 0, 0, 2'b00, dst, 1, ld, 1, 0); settle(); clk();
    endtask

    task automatic bubble();
        drive(0, 0, 0, 2'b00, 0, 0, 0, 1, 0); settle(); clk();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0;
            for (int k = 0; k < NS; k++) begin mv[i][k] = 0; mw[i][k] = 0; ml[i][k] = 0; md[i][k] = 0; end
        end
        do_reset();
        drive(1, 3, 3, 2'b11, 3, 1, 0, 1, 0); settle();
        chk("rst_occ", occ_a, 0); chk("rst_cnt", cnt_a, 0);
        chk("rst_stall", stall_a, 0); chk("rst_fwd", fwd_a, 0);
        clk();

        // ALU result forwarded from entry 0, entry 1, and youngest of two producers
        do_reset(); issue(3, 0);
        drive(1, 3, 0, 2'b01, 9, 0, 0, 1, 0); settle();
        chk("alu_fwd1", fwd_a, 1); chk("alu_nostall", stall_a, 0); clk();
        do_reset(); issue(3, 0); bubble();
        drive(1, 3, 0, 2'b01, 9, 0, 0, 1, 0); settle();
        chk("alu_fwd2", fwd_a, 2); clk();
        do_reset(); issue(4, 0); issue(4, 0);
        drive(1, 4, 0, 2'b01, 9, 0, 0, 1, 0); settle();
        chk("youngest", fwd_a, 1); clk();

        // load-use stall then forward from entry 1
        do_reset(); issue(5, 1);
        drive(1, 0, 5, 2'b10, 9, 0, 0, 1, 0); settle();
        chk("ld_stall", stall_a, 1); chk("ld_fwd0", fwd_a, 0); clk();
        settle();
        chk("ld_cnt", cnt_a, 1); chk("ld_nostall", stall_a, 0); chk("ld_fwd2", fwd_a, 8); clk();
        do_reset(); issue(5, 1);
        drive(1, 0, 5, 2'b10, 9, 0, 0, 0, 1);
        repeat (3) begin
            settle(); chk("frz_occ", occ_a, 3'b001); chk("frz_cnt", cnt_a, 0); clk();
        end

        // register 0 never matches
        do_reset(); issue(0, 0);
        drive(1, 0, 0, 2'b01, 9, 0, 0, 1, 0); settle();
        chk("r0_fwd", fwd_a, 0); chk("r0_stall", stall_a, 0); chk("r0_stall_b", stall_b, 0); clk();

        // flush clears two youngest entries, entry 1 shifts to entry 2
        do_reset(); issue(7, 0); bubble();
        drive(1, 0, 0, 2'b00, 6, 1, 0, 1, 1); settle(); clk();
        drive(1, 7, 0, 2'b01, 9, 0, 0, 1, 0); settle();
        chk("fl_occ", occ_a, 3'b100); chk("fl_fwd3", fwd_a, 3); chk("fl_nostall", stall_a, 0);
        chk("fl_b_fwd", fwd_b, 0); clk();

        // stall-only mode: two stall cycles then register-file bypass
        do_reset(); issue(2, 0);
        drive(1, 2, 0, 2'b01, 9, 0, 0, 1, 0);
        settle(); chk("nf_stall1", stall_b, 1); clk();
        settle(); chk("nf_stall2", stall_b, 1); clk();
        settle(); chk("nf_go", stall_b, 0); chk("nf_fwd", fwd_b, 0); chk("nf_cnt", cnt_b, 2); clk();

        // randomized traffic on a small register set to provoke hazards
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            nRST = ($urandom_range(0, 99) >= 2);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 7),
                  2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0);
            settle(); clk();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
